tdm_demux_1to4: RTL and testbench

- Sequential 1-to-4 time-division demultiplexer. It is the receive end of a 4:1 mux serializer, whose select counter walks lanes 0..3.
- Takes one WIDTH-bit beat per accepted cycle, steers it to lane sel, and publishes all four lanes together once a frame is complete.
- Sits after the serial link and before the parallel consumer.

---
 rtl/tdm_demux_1to4.sv | 148 ++++++++++++++
 tb/tb_tdm_demux_1to4.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux_1to4.sv
//-----------------------------------------------------------------------------
// tdm_demux_1to4
//
// Receive end of a 4:1 time-division serializer. Each accepted beat is
// steered into one of four lanes of an internal staging buffer; once the
// fourth lane arrives, the completed frame is published on data_out in a
// single update. The consumer therefore never sees a partially assembled
// frame.
//
// A frame always begins with a beat flagged by frame_start (lane 0). The
// following three non-start beats fill lanes 1..3 in order. Beats that arrive
// while hunting for a frame without frame_start are dropped. A frame_start
// that shows up before lane 3 has been filled aborts the partial frame,
// raises frame_err for one cycle and restarts collection with that beat as
// the new lane 0.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous reset, active-high, wins over all other inputs
//   in_valid     data_in carries a beat this cycle
//   frame_start  marks the beat as lane 0 of a new frame (only with in_valid)
//   data_in      serial beat, WIDTH bits
//   sel          lane the next accepted non-start beat will be written to
//   data_out     last complete frame, lane k at [k*WIDTH +: WIDTH]
//   out_valid    one-cycle pulse: data_out has just been refreshed
//   frame_err    one-cycle pulse: a partial frame was aborted by frame_start
//-----------------------------------------------------------------------------
module tdm_demux_1to4 #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               frame_start,
  input  logic [WIDTH-1:0]   data_in,
  output logic [1:0]         sel,
  output logic [4*WIDTH-1:0] data_out,
  output logic               out_valid,
  output logic               frame_err
);

  // IDLE hunts for a frame_start beat; COLLECT fills lanes 1..3.
  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  // Last lane index; reaching it while collecting completes the frame.
  localparam logic [1:0] LAST_LANE = 2'd3;

  state_t               r_state;
  state_t               w_nextState;
  logic [1:0]           r_sel;
  logic [1:0]           w_nextSel;
  logic [4*WIDTH-1:0]   r_stage;
  logic [4*WIDTH-1:0]   w_nextStage;
  logic [4*WIDTH-1:0]   r_dataOut;
  logic [4*WIDTH-1:0]   w_nextDataOut;
  logic                 r_outValid;
  logic                 w_nextOutValid;
  logic                 r_frameErr;
  logic                 w_nextFrameErr;

  // The staging buffer, frame output and lane pointer all live in one
  // register stage. Reset clears everything, including a half-built frame,
  // and deliberately produces no error pulse. Outside of reset each register
  // simply takes the value decided by the next-state logic below.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_sel      <= 2'd0;
      r_stage    <= '0;
      r_dataOut  <= '0;
      r_outValid <= 1'b0;
      r_frameErr <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_sel      <= w_nextSel;
      r_stage    <= w_nextStage;
      r_dataOut  <= w_nextDataOut;
      r_outValid <= w_nextOutValid;
      r_frameErr <= w_nextFrameErr;
    end
  end

  // Next-state and datapath decisions. Every value defaults to holding its
  // current contents and both pulses default low, so a cycle without
  // in_valid changes nothing and the pulses last exactly one cycle.
  //
  // On the fourth beat the published frame is assembled from staging lanes
  // 0..2 plus data_in directly, because lane 3 of staging is only written at
  // that same edge and would otherwise be one cycle stale. This lets the
  // next frame's lane 0 be accepted on the very next cycle with no bubble.
  always_comb begin
    w_nextState    = r_state;
    w_nextSel      = r_sel;
    w_nextStage    = r_stage;
    w_nextDataOut  = r_dataOut;
    w_nextOutValid = 1'b0;
    w_nextFrameErr = 1'b0;

    if (in_valid) begin
      unique case (r_state)
        IDLE: begin
          // Only a frame_start beat can open a frame; anything else is
          // noise between frames and is dropped without comment.
          if (frame_start) begin
            w_nextStage[0 +: WIDTH] = data_in;
            w_nextSel               = 2'd1;
            w_nextState             = COLLECT;
          end
        end

        COLLECT: begin
          if (frame_start) begin
            // Early start: abandon the partial frame, flag it, and treat
            // this beat as lane 0 of a fresh frame. data_out is untouched.
            w_nextFrameErr          = 1'b1;
            w_nextStage[0 +: WIDTH] = data_in;
            w_nextSel               = 2'd1;
            w_nextState             = COLLECT;
          end else if (r_sel == LAST_LANE) begin
            w_nextStage[3*WIDTH +: WIDTH] = data_in;
            w_nextDataOut  = {data_in, r_stage[3*WIDTH-1:0]};
            w_nextOutValid = 1'b1;
            w_nextSel      = 2'd0;
            w_nextState    = IDLE;
          end else begin
            w_nextStage[int'(r_sel)*WIDTH +: WIDTH] = data_in;
            w_nextSel = r_sel + 2'd1;
          end
        end

        default: begin
          w_nextState = IDLE;
          w_nextSel   = 2'd0;
        end
      endcase
    end
  end

  // Outputs come straight from registers; the staging buffer is internal.
  assign sel       = r_sel;
  assign data_out  = r_dataOut;
  assign out_valid = r_outValid;
  assign frame_err = r_frameErr;

endmodule

// File: tb/tb_tdm_demux_1to4.sv
//-----------------------------------------------------------------------------
// tb_tdm_demux_1to4
//
// Directed bench for tdm_demux_1to4. Three instances (WIDTH 1, 4 and 8)
// share clock, reset and control inputs; each gets the low bits of one
// shared 8-bit beat. Each scenario checks the instance whose width it
// targets against hand-computed values.
//-----------------------------------------------------------------------------
module tb_tdm_demux_1to4;

  logic       clk;
  logic       rst;
  logic       inValid;
  logic       frameStart;
  logic [7:0] beat;

  logic [1:0]  sel1;
  logic [3:0]  dataOut1;
  logic        outValid1;
  logic        frameErr1;

  logic [1:0]  sel4;
  logic [15:0] dataOut4;
  logic        outValid4;
  logic        frameErr4;

  logic [1:0]  sel8;
  logic [31:0] dataOut8;
  logic        outValid8;
  logic        frameErr8;

  int vectorCount = 0;
  int missCount   = 0;

  tdm_demux_1to4 #(.WIDTH(1)) dutW1 (
    .clk(clk), .rst(rst), .in_valid(inValid), .frame_start(frameStart),
    .data_in(beat[0:0]), .sel(sel1), .data_out(dataOut1),
    .out_valid(outValid1), .frame_err(frameErr1)
  );

  tdm_demux_1to4 #(.WIDTH(4)) dutW4 (
    .clk(clk), .rst(rst), .in_valid(inValid), .frame_start(frameStart),
    .data_in(beat[3:0]), .sel(sel4), .data_out(dataOut4),
    .out_valid(outValid4), .frame_err(frameErr4)
  );

  tdm_demux_1to4 #(.WIDTH(8)) dutW8 (
    .clk(clk), .rst(rst), .in_valid(inValid), .frame_start(frameStart),
    .data_in(beat), .sel(sel8), .data_out(dataOut8),
    .out_valid(outValid8), .frame_err(frameErr8)
  );

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, let the next rising edge take them, then
  // settle 1 unit past the edge so outputs can be sampled safely.
  task automatic applyStimulus(input logic r, input logic v, input logic fs,
                               input logic [7:0] d);
    rst        = r;
    inValid    = v;
    frameStart = fs;
    beat       = d;
    @(posedge clk);
    #1;
  endtask

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst        = 1'b1;
    inValid    = 1'b0;
    frameStart = 1'b0;
    beat       = 8'h00;

    // Reset held two cycles with junk on the inputs.
    applyStimulus(1'b1, 1'b1, 1'b1, 8'hFF);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'hFF);
    checkOutput("rst_sel",   32'(sel1),      32'd0);
    checkOutput("rst_dout",  32'(dataOut1),  32'h0);
    checkOutput("rst_ov",    32'(outValid1), 32'd0);
    checkOutput("rst_err",   32'(frameErr1), 32'd0);
    checkOutput("rst_dout8", dataOut8,       32'h0);

    // Basic WIDTH=1 frame: 1(fs),0,1,1 -> 4'b1101, sel 1,2,3,0.
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h01);
    checkOutput("w1_sel_a", 32'(sel1), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("w1_sel_b", 32'(sel1), 32'd2);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h01);
    checkOutput("w1_sel_c", 32'(sel1), 32'd3);
    checkOutput("w1_ov_early", 32'(outValid1), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h01);
    checkOutput("w1_sel_d", 32'(sel1),      32'd0);
    checkOutput("w1_ov",    32'(outValid1), 32'd1);
    checkOutput("w1_dout",  32'(dataOut1),  32'hD);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("w1_ov_pulse", 32'(outValid1), 32'd0);
    checkOutput("w1_dout_hold", 32'(dataOut1), 32'hD);

    // WIDTH=4 gaps and drops: A dropped, then 1,-,2,-,-,3,4 -> 16'h4321.
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h0A);
    checkOutput("w4_drop_sel", 32'(sel4),      32'd0);
    checkOutput("w4_drop_err", 32'(frameErr4), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h01);
    checkOutput("w4_sel_1", 32'(sel4), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'hEE);
    checkOutput("w4_gap_sel", 32'(sel4), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h02);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'hEE);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'hEE);
    checkOutput("w4_gap_sel2", 32'(sel4), 32'd2);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h03);
    checkOutput("w4_ov_early", 32'(outValid4), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h04);
    checkOutput("w4_ov",   32'(outValid4), 32'd1);
    checkOutput("w4_dout", 32'(dataOut4),  32'h4321);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("w4_ov_pulse", 32'(outValid4), 32'd0);

    // WIDTH=4 early start: 5(fs),6,7(fs),8,9,B -> err once, then 16'hB987.
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h05);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h06);
    checkOutput("es_err_pre", 32'(frameErr4), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h07);
    checkOutput("es_err",   32'(frameErr4), 32'd1);
    checkOutput("es_sel",   32'(sel4),      32'd1);
    checkOutput("es_hold",  32'(dataOut4),  32'h4321);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h08);
    checkOutput("es_err_pulse", 32'(frameErr4), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h09);
    checkOutput("es_hold2", 32'(dataOut4), 32'h4321);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h0B);
    checkOutput("es_ov",   32'(outValid4), 32'd1);
    checkOutput("es_dout", 32'(dataOut4),  32'hB987);
    checkOutput("es_err_end", 32'(frameErr4), 32'd0);

    // WIDTH=8 back-to-back frames, no bubble.
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h01);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h02);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h03);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h04);
    checkOutput("b2b_ov1",   32'(outValid8), 32'd1);
    checkOutput("b2b_dout1", dataOut8,       32'h04030201);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h11);
    checkOutput("b2b_ov_gap1", 32'(outValid8), 32'd0);
    checkOutput("b2b_sel",     32'(sel8),      32'd1);
    checkOutput("b2b_err",     32'(frameErr8), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h12);
    checkOutput("b2b_ov_gap2", 32'(outValid8), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h13);
    checkOutput("b2b_ov_gap3", 32'(outValid8), 32'd0);
    checkOutput("b2b_hold",    dataOut8,       32'h04030201);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h14);
    checkOutput("b2b_ov2",   32'(outValid8), 32'd1);
    checkOutput("b2b_dout2", dataOut8,       32'h14131211);

    // Mid-frame reset discards everything silently; next frame is normal.
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h21);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h22);
    checkOutput("mr_sel_pre", 32'(sel8), 32'd2);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("mr_sel",  32'(sel8),      32'd0);
    checkOutput("mr_dout", dataOut8,       32'h0);
    checkOutput("mr_ov",   32'(outValid8), 32'd0);
    checkOutput("mr_err",  32'(frameErr8), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h31);
    checkOutput("mr_err_after", 32'(frameErr8), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h32);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h33);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h34);
    checkOutput("mr_ov_frame", 32'(outValid8), 32'd1);
    checkOutput("mr_dout_frame", dataOut8,     32'h34333231);

    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
